// File: rtl/oled_pkg.sv
// Shared SSD1306 command codes, frame geometry and FSM encodings for the OLED SPI driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
package oled_pkg;

    localparam logic [7:0] DISPLAY_OFF   = 8'hAE;
    localparam logic [7:0] DISPLAY_ON    = 8'hAF;
    localparam logic [7:0] SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] SET_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CHARGE_PUMP   = 8'h8D;
    localparam logic [7:0] MEM_MODE      = 8'h20;

    localparam int FRAME_BYTES = 1024;
    localparam int ADDR_LEN    = 6;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        INIT_LOAD,
        ADDR_LOAD,
        FETCH,
        SHIFT,
        GAP
    } state_t;

    // What the byte currently on the wire is, so GAP knows how to advance.
    typedef enum logic [1:0] {
        KIND_INIT,
        KIND_ADDR,
        KIND_PIX
    } kind_t;

endpackage

// File: rtl/oled_init_rom.sv
// Combinational init-list ROM; the 6-byte address window sits at offsets INIT_LEN..INIT_LEN+5.
// Latency: 0 clk (pure lookup).
// Backpressure: none.
module oled_init_rom #(
    parameter int INIT_LEN = 25
) (
    input  logic [4:0] addr,
    output logic [7:0] dat
);
    import oled_pkg::*;

    localparam logic [4:0] INIT_BASE = 5'(INIT_LEN);

    logic [4:0] off;

    always_comb begin
        off = addr - INIT_BASE;
        dat = 8'h00;
        if (addr < INIT_BASE) begin
            case (addr)
                5'd0:    dat = DISPLAY_OFF;
                5'd1:    dat = 8'hD5;
                5'd2:    dat = 8'h80;
                5'd3:    dat = 8'hA8;
                5'd4:    dat = 8'h3F;
                5'd5:    dat = 8'hD3;
                5'd6:    dat = 8'h00;
                5'd7:    dat = 8'h40;
                5'd8:    dat = CHARGE_PUMP;
                5'd9:    dat = 8'h14;
                5'd10:   dat = MEM_MODE;
                5'd11:   dat = 8'h00;       // horizontal addressing
                5'd12:   dat = 8'hA1;
                5'd13:   dat = 8'hC8;
                5'd14:   dat = 8'hDA;
                5'd15:   dat = 8'h12;
                5'd16:   dat = 8'h81;
                5'd17:   dat = 8'hCF;
                5'd18:   dat = 8'hD9;
                5'd19:   dat = 8'hF1;
                5'd20:   dat = 8'hDB;
                5'd21:   dat = 8'h40;
                5'd22:   dat = 8'hA4;
                5'd23:   dat = 8'hA6;
                5'd24:   dat = DISPLAY_ON;
                default: dat = 8'h00;
            endcase
        end else begin
            case (off)
                5'd0:    dat = SET_COL_ADDR;
                5'd1:    dat = 8'h00;
                5'd2:    dat = 8'h7F;
                5'd3:    dat = SET_PAGE_ADDR;
                5'd4:    dat = 8'h00;
                5'd5:    dat = 8'h07;
                default: dat = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1306 bring-up (reset pulse + init list) then endless frames of address window + 1024 pixel bytes.
// Latency: byte_counter leads data_in capture by 2 clk; each byte is 16*CLK_DIV SHIFT + CLK_DIV GAP clk.
// Backpressure: none; the upstream image controller must answer byte_counter within 1 clk.
module oled_spi_driver #(
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 270000,
    parameter int INIT_LEN     = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    output logic [9:0] byte_counter,
    output logic       oled_sclk,
    output logic       oled_sdin,
    output logic       oled_dc,
    output logic       oled_cs_n,
    output logic       oled_res_n,
    output logic       init_done,
    output logic       frame_done
);
    import oled_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [4:0]       INIT_LAST = 5'(INIT_LEN - 1);
    localparam logic [4:0]       INIT_BASE = 5'(INIT_LEN);
    localparam logic [4:0]       ADDR_LAST = 5'(ADDR_LEN - 1);
    localparam logic [9:0]       PIX_LAST  = 10'(FRAME_BYTES - 1);

    state_t           state;
    state_t           state_nxt;
    kind_t            kind;
    logic [RST_W-1:0] reset_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       sreg;
    logic [4:0]       idx;
    logic [4:0]       rom_addr;
    logic [7:0]       rom_dat;
    logic [9:0]       pix_idx;
    logic             sclk_q;
    logic             dc_q;

    logic div_last;
    logic rst_last;
    logic fetch_last;
    logic bit_done;
    logic gap_end;
    logic last_init;
    logic last_addr;
    logic last_pix;
    logic counting;

    oled_init_rom #(
        .INIT_LEN (INIT_LEN)
    ) u_rom (
        .addr (rom_addr),
        .dat  (rom_dat)
    );

    assign div_last   = (div_cnt == DIV_LAST);
    assign rst_last   = (reset_cnt == RST_LAST);
    assign fetch_last = (div_cnt == DIV_W'(1));
    // bit_done marks the SCLK high->low transition, where the next bit is shifted out.
    assign bit_done   = (state == SHIFT) && div_last && sclk_q;
    assign gap_end    = (state == GAP) && div_last;
    assign last_init  = (idx == INIT_LAST);
    assign last_addr  = (idx == ADDR_LAST);
    assign last_pix   = (pix_idx == PIX_LAST);
    assign counting   = (state == FETCH) || (state == SHIFT) || (state == GAP);

    assign oled_sclk  = sclk_q;
    assign oled_sdin  = sreg[7];
    assign oled_dc    = dc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST_LOW:   if (rst_last) state_nxt = RST_WAIT;
            RST_WAIT:  if (rst_last) state_nxt = INIT_LOAD;
            INIT_LOAD: state_nxt = SHIFT;
            ADDR_LOAD: state_nxt = SHIFT;
            FETCH:     if (fetch_last) state_nxt = SHIFT;
            SHIFT:     if (bit_done && bit_cnt == 3'd7) state_nxt = GAP;
            GAP: begin
                if (div_last) begin
                    case (kind)
                        KIND_INIT: state_nxt = last_init ? ADDR_LOAD : INIT_LOAD;
                        KIND_ADDR: state_nxt = last_addr ? FETCH : ADDR_LOAD;
                        default:   state_nxt = last_pix ? ADDR_LOAD : FETCH;
                    endcase
                end
            end
            default:   state_nxt = RST_LOW;
        endcase
    end

    always_comb begin
        oled_res_n = (state != RST_LOW);
        oled_cs_n  = (state != SHIFT);
        rom_addr   = (kind == KIND_ADDR) ? (idx + INIT_BASE) : idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_cnt <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sclk_q    <= 1'b0;
            sreg      <= 8'h00;
        end else begin
            if ((state == RST_LOW || state == RST_WAIT) && !rst_last) begin
                reset_cnt <= reset_cnt + 1'b1;
            end else begin
                reset_cnt <= '0;
            end

            if (counting && state_nxt == state && !div_last) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            if (state == SHIFT) begin
                if (div_last) sclk_q <= ~sclk_q;
            end else begin
                sclk_q <= 1'b0;
            end

            if (bit_done) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else if (state != SHIFT) begin
                bit_cnt <= '0;
            end

            if (state == INIT_LOAD || state == ADDR_LOAD) begin
                sreg <= rom_dat;
            end else if (state == FETCH && fetch_last) begin
                sreg <= data_in;
            end else if (bit_done) begin
                sreg <= {sreg[6:0], 1'b0};
            end
        end
    end

    // Byte bookkeeping: kind/dc change on entry to LOAD/FETCH so dc is stable through GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind         <= KIND_INIT;
            dc_q         <= 1'b0;
            idx          <= '0;
            pix_idx      <= '0;
            byte_counter <= '0;
            init_done    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (state_nxt != state) begin
                case (state_nxt)
                    INIT_LOAD: begin kind <= KIND_INIT; dc_q <= 1'b0; end
                    ADDR_LOAD: begin kind <= KIND_ADDR; dc_q <= 1'b0; end
                    FETCH:     begin kind <= KIND_PIX;  dc_q <= 1'b1; end
                    default: ;
                endcase
            end

            if (gap_end && state_nxt == FETCH) begin
                byte_counter <= (kind == KIND_PIX) ? (pix_idx + 1'b1) : 10'd0;
            end

            if (gap_end) begin
                case (kind)
                    KIND_INIT: begin
                        if (last_init) begin
                            idx       <= '0;
                            init_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    KIND_ADDR: begin
                        if (last_addr) begin
                            idx     <= '0;
                            pix_idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: begin
                        pix_idx <= pix_idx + 1'b1;
                        if (last_pix) frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_driver.sv
// Scoreboard bench: expected SPI bytes are queued by the stimulus, a negedge monitor decodes and compares.
module tb_oled_spi_driver;
    localparam int CLK_DIV      = 2;
    localparam int RESET_CYCLES = 10;
    localparam int INIT_LEN     = 25;
    localparam int CMD_CLKS     = 17 * CLK_DIV + 1;
    localparam int PIX_CLKS     = 17 * CLK_DIV + 2;
    localparam int FRAME_CLKS   = 6 * CMD_CLKS + 1024 * PIX_CLKS;     // 37074
    localparam int INIT_CLKS    = (INIT_LEN - 1) * CMD_CLKS + 17 * CLK_DIV;

    typedef struct packed {
        logic       dc;
        logic [7:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in = 8'h00;
    logic [9:0] byte_counter;
    logic       oled_sclk, oled_sdin, oled_dc, oled_cs_n, oled_res_n;
    logic       init_done, frame_done;

    int   vectors = 0;
    int   miscompares = 0;
    int   nbytes = 0;
    int   frame_pulses = 0;
    exp_t exp_q[$];

    logic [7:0] init_tab [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] addr_tab [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    oled_spi_driver #(
        .CLK_DIV      (CLK_DIV),
        .RESET_CYCLES (RESET_CYCLES),
        .INIT_LEN     (INIT_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .byte_counter (byte_counter),
        .oled_sclk    (oled_sclk),
        .oled_sdin    (oled_sdin),
        .oled_dc      (oled_dc),
        .oled_cs_n    (oled_cs_n),
        .oled_res_n   (oled_res_n),
        .init_done    (init_done),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Image controller model: registered lookup, one clk behind byte_counter.
    always @(posedge clk) data_in <= byte_counter[7:0] ^ 8'h5A;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic push_cmds(input bit with_init);
        if (with_init) begin
            for (int i = 0; i < INIT_LEN; i++) exp_q.push_back({1'b0, init_tab[i]});
        end
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, addr_tab[i]});
    endtask

    task automatic push_pix(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back({1'b1, 8'(i) ^ 8'h5A});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " oled_res_n"},   32'(oled_res_n),   32'd0);
        check({tag, " oled_cs_n"},    32'(oled_cs_n),    32'd1);
        check({tag, " oled_sclk"},    32'(oled_sclk),    32'd0);
        check({tag, " oled_sdin"},    32'(oled_sdin),    32'd0);
        check({tag, " oled_dc"},      32'(oled_dc),      32'd0);
        check({tag, " byte_counter"}, 32'(byte_counter), 32'd0);
        check({tag, " init_done"},    32'(init_done),    32'd0);
        check({tag, " frame_done"},   32'(frame_done),   32'd0);
    endtask

    task automatic release_and_time_reset();
        int cnt;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (!oled_res_n && cnt < 1000);
        check("oled_res_n low clk", 32'(cnt), 32'(RESET_CYCLES));
        cnt = 0;
        do begin @(posedge clk); #1; cnt++; end while (oled_cs_n && cnt < 1000);
        // RST_WAIT plus the single INIT_LOAD clk before cs_n falls.
        check("oled_res_n high to cs_n fall clk", 32'(cnt), 32'(RESET_CYCLES + 1));
    endtask

    // SPI monitor: decode on SCLK rising, compare each completed byte against the queue.
    logic       prev_sclk, prev_cs, first_byte, dc_bad, byte_dc;
    logic [7:0] sh;
    int         bits, hi_run, lo_run;
    exp_t       e;

    always @(negedge clk) begin
        if (frame_done) frame_pulses++;
        if (!rst_n) begin
            bits = 0; nbytes = 0; first_byte = 1'b1; prev_sclk = 1'b0; prev_cs = 1'b1;
            hi_run = 0; lo_run = 0; dc_bad = 1'b0; byte_dc = 1'b0; sh = 8'h00;
        end else begin
            if (oled_cs_n) begin
                if (!prev_cs) check("cs_n low clk", 32'(lo_run), 32'(16 * CLK_DIV));
                hi_run++;
                lo_run = 0;
                bits = 0;
            end else begin
                if (prev_cs) begin
                    if (!first_byte)
                        check("cs_n high clk", 32'(hi_run), oled_dc ? 32'(CLK_DIV + 2) : 32'(CLK_DIV + 1));
                    check("sclk idle at cs_n fall", 32'(oled_sclk), 32'd0);
                    first_byte = 1'b0;
                    hi_run = 0;
                    dc_bad = 1'b0;
                    byte_dc = oled_dc;
                end
                lo_run++;
                if (oled_sclk && !prev_sclk) begin
                    sh = {sh[6:0], oled_sdin};
                    if (oled_dc !== byte_dc) dc_bad = 1'b1;
                    bits++;
                    if (bits == 8) begin
                        bits = 0;
                        nbytes++;
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected spi byte: got dc=%0b 0x%02h, want none", oled_dc, sh);
                        end else begin
                            e = exp_q.pop_front();
                            check("spi byte {dc_unstable,dc,data}", 32'({dc_bad, oled_dc, sh}), 32'({1'b0, e}));
                            check("init_done at byte end", 32'(init_done), 32'(nbytes > INIT_LEN));
                        end
                    end
                end
            end
            prev_sclk = oled_sclk;
            prev_cs = oled_cs_n;
        end
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        push_cmds(1'b1);
        push_pix(0, 1023);
        push_cmds(1'b0);
        push_pix(0, 500);
        release_and_time_reset();

        cnt = 0;
        while (!init_done && cnt < 2000) begin @(posedge clk); #1; cnt++; end
        check("init_done rises", 32'(init_done), 32'd1);
        check("init duration clk", 32'(cnt), 32'(INIT_CLKS));
        check("bytes before init_done", 32'(nbytes), 32'(INIT_LEN));

        cnt = 0;
        while (!frame_done && cnt < FRAME_CLKS + 100) begin @(posedge clk); #1; cnt++; end
        check("frame_done rises", 32'(frame_done), 32'd1);
        check("init_done to frame_done clk", 32'(cnt), 32'(FRAME_CLKS));
        check("bytes at frame_done", 32'(nbytes), 32'(INIT_LEN + 6 + 1024));
        @(posedge clk);
        #1;
        check("frame_done pulse width", 32'(frame_done), 32'd0);
        check("byte_counter held after frame", 32'(byte_counter), 32'd1023);

        cnt = 0;
        while (!(byte_counter == 10'd500 && !oled_cs_n) && cnt < 30000) begin @(posedge clk); #1; cnt++; end
        check("reached pixel 500 shift", 32'(byte_counter), 32'd500);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-frame reset");
        check("bytes before mid-frame reset", 32'(nbytes), 32'(INIT_LEN + 6 + 1024 + 6 + 500));
        check("pending bytes at reset", 32'(exp_q.size()), 32'd1);
        check("frame_done pulses", 32'(frame_pulses), 32'd1);

        exp_q.delete();
        push_cmds(1'b1);
        push_pix(0, 1);
        repeat (3) @(posedge clk);
        release_and_time_reset();

        cnt = 0;
        while (exp_q.size() != 0 && cnt < 3000) begin @(posedge clk); #1; cnt++; end
        check("re-init bytes all sent", 32'(exp_q.size()), 32'd0);
        check("init_done after re-init", 32'(init_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oled_spi_driver.md
Name: oled_spi_driver

Overview:
Downstream consumer of the image/status-bar controller. Brings up a 128x64 SSD1306 OLED over 4-wire SPI: hardware reset pulse, then the init command list. It then streams frames forever. Each frame is a 6-byte address-window command, then 1024 display-RAM bytes. The block drives `byte_counter` (0..1023) to the image controller and serialises the returned `data_in` byte.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2).
- RESET_CYCLES, 270000, clk cycles `oled_res_n` is held low after `rst_n` release (10 ms at 27 MHz); also used as post-reset wait.
- INIT_LEN, 25, number of bytes in the init command ROM.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- data_in  in  8  pixel byte from the image controller, valid 1 clk after `byte_counter` changes.
- byte_counter  out  10  display-RAM byte index requested from the image controller.
- oled_sclk  out  1  SPI clock, idle low.
- oled_sdin  out  1  SPI MOSI.
- oled_dc  out  1  0=command, 1=data.
- oled_cs_n  out  1  chip select, active low.
- oled_res_n  out  1  panel reset, active low.
- init_done  out  1  high once the init list is fully sent; stays high until reset.
- frame_done  out  1  1-clk pulse after the last (1024th) data byte's final SCLK edge.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values (immediate on `rst_n`=0, including mid-byte): `oled_res_n`=0, `oled_cs_n`=1, `oled_sclk`=0, `oled_sdin`=0, `oled_dc`=0, `byte_counter`=0, `init_done`=0, `frame_done`=0. FSM goes to RST_LOW and any in-flight byte is abandoned. After release the full init sequence is repeated.
- FSM states:
  - RST_LOW: `oled_res_n`=0 for RESET_CYCLES → RST_WAIT.
  - RST_WAIT: `oled_res_n`=1 for RESET_CYCLES → INIT_LOAD.
  - INIT_LOAD: shift reg ← `init_rom[idx]`, `oled_dc`=0 → SHIFT.
  - ADDR_LOAD: shift reg ← `addr_rom[idx]` (21 00 7F 22 00 07), `oled_dc`=0 → SHIFT.
  - FETCH: `byte_counter` ← `pix_idx` on entry. Stay exactly 2 clk, then capture `data_in` into the shift reg with `oled_dc`=1 → SHIFT.
  - SHIFT: 8 bits, then GAP.
  - GAP: `oled_cs_n`=1 for CLK_DIV clk, then advance.
- Advance rules:
  - Init: idx<INIT_LEN-1 → INIT_LOAD. Otherwise set `init_done`=1 and go to ADDR_LOAD (idx=0).
  - Addr: idx<5 → ADDR_LOAD. Otherwise go to FETCH with `pix_idx`=0.
  - Pixel: `pix_idx`<1023 → `pix_idx`+1, FETCH. At 1023: pulse `frame_done`, `pix_idx` wraps to 0, go to ADDR_LOAD.
- SPI byte timing (mode 0, MSB first):
  - `oled_cs_n` falls and `oled_sdin`=bit7 on SHIFT entry.
  - Per bit: `oled_sclk` low CLK_DIV clk, then high CLK_DIV clk (panel samples on the rising edge).
  - `oled_sdin` updates only on the high→low transition.
  - `oled_dc` is stable from LOAD/FETCH through the end of GAP.
  - One byte = 16·CLK_DIV clk SHIFT + CLK_DIV clk GAP.
- Counters:
  - Divider counter: 0..CLK_DIV-1.
  - Bit counter: 3 bits.
  - `pix_idx`: 10 bits, natural wrap.
  - `reset_cnt`: wide enough for RESET_CYCLES.
- Frame length: 6 command bytes + 1024 data bytes; there is no stall input.
- `byte_counter` holds its value outside FETCH, so the upstream mux output is stable.

Decomposition:
- Shared package `oled_pkg`:
  - SSD1306 command constants (DISPLAY_OFF 0xAE, DISPLAY_ON 0xAF, SET_COL_ADDR 0x21, SET_PAGE_ADDR 0x22, CHARGE_PUMP 0x8D, MEM_MODE 0x20).
  - FSM state encoding.
  - FRAME_BYTES=1024.
- Sub-module `oled_init_rom`: combinational lookup idx→byte for the init list.
  - Contents: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF (horizontal addressing mode).
  - The 6-byte address table lives in the same ROM at offsets INIT_LEN..INIT_LEN+5.

Test Plan:
- Reset pulse: CLK_DIV=2, RESET_CYCLES=10, release `rst_n` → `oled_res_n` low exactly 10 clk, high 10 clk, then `oled_cs_n` falls.
- First init byte: decode SPI on SCLK rising edges → first byte 0xAE with `oled_dc`=0. 25 bytes follow matching the ROM. `init_done` rises after byte 25 (0xAF). Each byte is 32 clk low-`cs_n` plus 2 clk gap.
- Address window: after init, the next 6 decoded bytes are 21 00 7F 22 00 07 with `oled_dc`=0.
- Pixel stream: model image controller with registered `data_in` = `byte_counter[7:0]` ^ 0x5A. Decoded data bytes 0..1023 equal 0x5A, 0x5B, …, and index 1023 gives 0xA5. `oled_dc`=1 throughout. `frame_done` pulses once, then the next 6 bytes are the address window again.
- Back-to-back frames: run 3 frames → exactly 3 `frame_done` pulses, spaced 1030·(17·CLK_DIV)+FETCH-overhead clk apart, identical each time.
- Mid-frame reset: assert `rst_n`=0 while shifting pixel byte 500 → same clk: `oled_cs_n`=1, `oled_sclk`=0, `oled_res_n`=0, `byte_counter`=0, `init_done`=0. On release the full reset pulse and init list are re-sent from 0xAE.
